// File: rtl/dec_pkg.sv
//------------------------------------------------------------------------------
// dec_pkg : shared types, widths and the one-hot helper for the 3-to-8 decoder
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dec_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [OUT_W-1:0] onehot(input logic [CODE_W-1:0] code);
    logic [OUT_W-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_3to8_strobe_if.sv
//------------------------------------------------------------------------------
// decoder_3to8_strobe_if : code handshake plus decoded strobe outputs
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface decoder_3to8_strobe_if;
  import dec_pkg::*;

  logic              en;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic [OUT_W-1:0]  y;
  logic              busy;
  logic              done;

  modport master (
    output en,
    output in_valid,
    output in_code,
    input  in_ready,
    input  y,
    input  busy,
    input  done
  );

  modport slave (
    input  en,
    input  in_valid,
    input  in_code,
    output in_ready,
    output y,
    output busy,
    output done
  );

endinterface

`default_nettype wire

// File: rtl/dec_pend_buf.sv
//------------------------------------------------------------------------------
// dec_pend_buf : one-entry code register with full flag, load and clear
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dec_pend_buf
  import dec_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              load,
  input  wire logic              clear,
  input  wire logic [CODE_W-1:0] load_code,
  output logic                   full,
  output logic [CODE_W-1:0]      code
);

  logic              r_full;
  logic [CODE_W-1:0] r_code;

  // Load and clear never coincide: load needs an empty buffer, clear a full one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_code <= '0;
    end else if (clear) begin
      r_full <= 1'b0;
    end else if (load) begin
      r_full <= 1'b1;
      r_code <= load_code;
    end
  end

  assign full = r_full;
  assign code = r_code;

endmodule

`default_nettype wire

// File: rtl/decoder_3to8_strobe.sv
//------------------------------------------------------------------------------
// decoder_3to8_strobe : registered 3-to-8 decoder, each line strobed HOLD_CYCLES
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module decoder_3to8_strobe
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  decoder_3to8_strobe_if.slave bus
);

  localparam logic [7:0] c_reload = 8'(HOLD_CYCLES - 1);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [OUT_W-1:0]  r_y;
  logic              r_busy;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_hold_end;
  logic              w_pend_full;
  logic [CODE_W-1:0] w_pend_code;
  logic              w_pend_load;
  logic              w_pend_clear;

  assign w_in_ready = bus.en & rst_n & ((r_state == IDLE) | ~w_pend_full);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_hold_end = bus.en & (r_state == HOLD) & (r_cnt == 8'd0);

  // A code arriving on the last hold clock bypasses the buffer straight into y.
  assign w_pend_load  = w_accept & (r_state == HOLD) & (r_cnt != 8'd0);
  assign w_pend_clear = w_hold_end & w_pend_full;

  dec_pend_buf u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_pend_load),
    .clear     (w_pend_clear),
    .load_code (bus.in_code),
    .full      (w_pend_full),
    .code      (w_pend_code)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_y     <= '0;
      r_busy  <= 1'b0;
    end else if (bus.en) begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_y     <= onehot(bus.in_code);
            r_busy  <= 1'b1;
            r_cnt   <= c_reload;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (r_cnt == 8'd0) begin
            if (w_pend_full) begin
              r_y   <= onehot(w_pend_code);
              r_cnt <= c_reload;
            end else if (w_accept) begin
              r_y   <= onehot(bus.in_code);
              r_cnt <= c_reload;
            end else begin
              r_y     <= '0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_y     <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.y        = r_y;
  assign bus.busy     = r_busy;
  assign bus.done     = w_hold_end;

endmodule

`default_nettype wire

// File: tb/tb_decoder_3to8_strobe.sv
// Bench for decoder_3to8_strobe: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances share
// one stimulus stream; each is compared with a two-deep code-queue reference model.
`default_nettype none

module tb_decoder_3to8_strobe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       valid;
  logic [2:0] code;

  always #5 clk = ~clk;

  decoder_3to8_strobe_if if4 ();
  decoder_3to8_strobe_if if1 ();

  assign if4.en       = en;
  assign if4.in_valid = valid;
  assign if4.in_code  = code;
  assign if1.en       = en;
  assign if1.in_valid = valid;
  assign if1.in_code  = code;

  decoder_3to8_strobe #(.HOLD_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  decoder_3to8_strobe #(.HOLD_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic [7:0] y_o     [2];
  logic       busy_o  [2];
  logic       done_o  [2];
  logic       ready_o [2];

  assign y_o[0]     = if4.y;
  assign y_o[1]     = if1.y;
  assign busy_o[0]  = if4.busy;
  assign busy_o[1]  = if1.busy;
  assign done_o[0]  = if4.done;
  assign done_o[1]  = if1.done;
  assign ready_o[0] = if4.in_ready;
  assign ready_o[1] = if1.in_ready;

  // Reference: per DUT, a queue of up to two codes (showing + waiting) and the
  // number of clocks the showing code still has on the output.
  int H    [2] = '{4, 1};
  int qsz  [2];
  int qc   [2][2];
  int rem  [2];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      qsz[d] = 0;
      rem[d] = 0;
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      logic [7:0] ey;
      ey = (qsz[d] > 0) ? (8'd1 << qc[d][0]) : 8'd0;
      chk($sformatf("y_H%0d", H[d]), y_o[d], ey);
      chk($sformatf("busy_H%0d", H[d]), {7'd0, busy_o[d]}, {7'd0, qsz[d] > 0});
      chk($sformatf("done_H%0d", H[d]), {7'd0, done_o[d]},
          {7'd0, (rst_n && en && qsz[d] > 0 && rem[d] == 1)});
      chk($sformatf("in_ready_H%0d", H[d]), {7'd0, ready_o[d]},
          {7'd0, (rst_n && en && qsz[d] < 2)});
      chk($sformatf("onehot0_H%0d", H[d]), {7'd0, $onehot0(y_o[d])}, 8'd1);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit acc;
      acc = en && valid && (qsz[d] < 2);
      if (en) begin
        if (qsz[d] > 0) begin
          rem[d]--;
          if (rem[d] == 0) begin
            qc[d][0] = qc[d][1];
            qsz[d]--;
            if (qsz[d] > 0) rem[d] = H[d];
          end
        end
        if (acc) begin
          qc[d][qsz[d]] = int'(code);
          qsz[d]++;
          if (qsz[d] == 1) rem[d] = H[d];
        end
      end
    end
  endtask

  task automatic cycle(input logic e, input logic v, input logic [2:0] c);
    en    = e;
    valid = v;
    code  = c;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [2:0] seq [3];
    int idx;
    bit will_acc;

    // Reset asserted while inputs are active
    rst_n = 1'b1; en = 1'b1; valid = 1'b1; code = 3'd5;
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all();
    chk("reset_y_const", if4.y, 8'h00);
    @(posedge clk); #1 check_all();
    @(posedge clk); #1 check_all();
    @(negedge clk); rst_n = 1'b1;
    #1 chk("ready_after_release", {7'd0, if4.in_ready}, 8'd1);
    @(posedge clk); #1;
    model_step();

    // Single code 5, then drain
    cycle(1'b1, 1'b1, 3'd5);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 3'd0);

    // Back-to-back 0,7,3 offered continuously
    seq = '{3'd0, 3'd7, 3'd3};
    idx = 0;
    for (int g = 0; g < 40 && idx < 3; g++) begin
      will_acc = (qsz[0] < 2);
      cycle(1'b1, 1'b1, seq[idx]);
      if (will_acc) idx++;
    end
    chk("b2b_all_accepted", 8'(idx), 8'd3);
    for (int i = 0; i < 14; i++) cycle(1'b1, 1'b0, 3'd0);

    // Pause mid-hold of code 2
    cycle(1'b1, 1'b1, 3'd2);
    cycle(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 3'd6);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 3'd0);

    // Codes 1,2,4 every clock (new line each clock on the HOLD_CYCLES=1 instance)
    cycle(1'b1, 1'b1, 3'd1);
    cycle(1'b1, 1'b1, 3'd2);
    cycle(1'b1, 1'b1, 3'd4);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 3'd0);

    // Code 3, then offer 6 exactly on its last hold clock
    cycle(1'b1, 1'b1, 3'd3);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'd0);
    cycle(1'b1, 1'b1, 3'd6);
    @(negedge clk);
    chk("bypass_y", if4.y, 8'h40);
    chk("bypass_busy", {7'd0, if4.busy}, 8'd1);
    @(posedge clk); model_step(); #1;
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 3'd0);

    // Reset in the middle of a hold with a pending code
    cycle(1'b1, 1'b1, 3'd5);
    cycle(1'b1, 1'b1, 3'd6);
    cycle(1'b1, 1'b0, 3'd0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk); #1 check_all();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_step();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 3'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
